hex_word_rx: RTL and testbench

HEX_WORD_RX -- requirements
Module: hex_word_rx

---
 rtl/hex_word_rx.sv | 142 ++++++++++++++
 tb/tb_hex_word_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_rx.sv
// Line parser for "0x<1..8 hex digits><CR|LF>" ASCII records from a UART receiver.
// Emits the parsed word with a one-cycle o_stb, or a one-cycle o_err on a malformed line.
module hex_word_rx #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_stb,
    input  logic [7:0]   i_byte,
    output logic         o_stb,
    output logic [W-1:0] o_data,
    output logic         o_err
);

    typedef enum logic [1:0] {IDLE, GOT0, DIGITS, ERR} state_t;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_UA    = 8'h41;
    localparam logic [7:0] CH_UF    = 8'h46;
    localparam logic [7:0] CH_UX    = 8'h58;
    localparam logic [7:0] CH_LA    = 8'h61;
    localparam logic [7:0] CH_LF_HX = 8'h66;
    localparam logic [7:0] CH_LX    = 8'h78;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   data_q, data_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           stb_q, stb_d;
    logic           err_q, err_d;

    logic           is_hex;
    logic           is_term;
    logic [3:0]     nibble;

    // Letters a-f / A-F share low nibbles 1..6, so +9 maps them to 10..15.
    always_comb begin
        is_hex = 1'b1;
        nibble = 4'd0;
        if (i_byte >= CH_0 && i_byte <= CH_9) begin
            nibble = i_byte[3:0];
        end else if ((i_byte >= CH_LA && i_byte <= CH_LF_HX) ||
                     (i_byte >= CH_UA && i_byte <= CH_UF)) begin
            nibble = i_byte[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
    end

    assign is_term = (i_byte == CH_CR) || (i_byte == CH_LF);

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        stb_d   = 1'b0;
        err_d   = 1'b0;
        if (i_stb) begin
            case (state_q)
                IDLE: begin
                    if (i_byte == CH_0) begin
                        state_d = GOT0;
                    end else if (!is_term && i_byte != CH_SP) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
                GOT0: begin
                    if (i_byte == CH_LX || i_byte == CH_UX) begin
                        state_d = DIGITS;
                        acc_d   = '0;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
                DIGITS: begin
                    if (is_hex) begin
                        if (cnt_q == 4'd8) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end else begin
                            acc_d = {acc_q[W-5:0], nibble};
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (is_term) begin
                        // An empty "0x" line is reported but needs no resync to LF.
                        state_d = IDLE;
                        if (cnt_q == 4'd0) begin
                            err_d = 1'b1;
                        end else begin
                            data_d = acc_q;
                            stb_d  = 1'b1;
                        end
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
                ERR: begin
                    if (i_byte == CH_LF) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= 4'd0;
            data_q  <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        o_stb  = stb_q;
        o_err  = err_q;
        o_data = data_q;
    end

endmodule

// File: tb/tb_hex_word_rx.sv
// Bench for hex_word_rx: directed line scenarios plus random lines, checked every
// cycle against a line-buffer reference model.
module tb_hex_word_rx;

    logic        clk;
    logic        i_reset;
    logic        i_stb;
    logic [7:0]  i_byte;
    logic        o_stb;
    logic [31:0] o_data;
    logic        o_err;

    hex_word_rx #(.W(32)) dut (
        .i_clk  (clk),
        .i_reset(i_reset),
        .i_stb  (i_stb),
        .i_byte (i_byte),
        .o_stb  (o_stb),
        .o_data (o_data),
        .o_err  (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_stb   = 0;
    int n_err   = 0;
    bit armed   = 1'b0;

    string cr_s;
    string lf_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffers the bytes of the current line and judges the whole
    // line text against the "0x<hex..><term>" grammar after each accepted byte.
    logic [7:0]  line_q[$];
    bit          m_in_err = 1'b0;
    bit          exp_stb  = 1'b0;
    bit          exp_err  = 1'b0;
    logic [31:0] exp_data = 32'h0;

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        return -1;
    endfunction

    function automatic bit is_term(input logic [7:0] c);
        return (c == 8'h0D) || (c == 8'h0A);
    endfunction

    function automatic void raise_err();
        exp_err  = 1'b1;
        m_in_err = 1'b1;
        line_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int n;
        logic [31:0] w;
        if (m_in_err) begin
            if (b == 8'h0A) m_in_err = 1'b0;
            return;
        end
        if (line_q.size() == 0 && (is_term(b) || b == 8'h20)) return;
        line_q.push_back(b);
        n = line_q.size();
        if (n == 1) begin
            if (b != 8'h30) raise_err();
            return;
        end
        if (n == 2) begin
            if (b != 8'h78 && b != 8'h58) raise_err();
            return;
        end
        if (is_term(b)) begin
            if (n == 3) begin
                exp_err = 1'b1;
            end else begin
                w = 32'h0;
                for (int k = 2; k < n - 1; k++) w = w * 32'd16 + 32'(hexval(line_q[k]));
                exp_stb  = 1'b1;
                exp_data = w;
            end
            line_q.delete();
            return;
        end
        if (hexval(b) < 0 || n - 2 > 8) raise_err();
    endfunction

    always @(posedge clk) begin
        exp_stb = 1'b0;
        exp_err = 1'b0;
        if (i_reset) begin
            line_q.delete();
            m_in_err = 1'b0;
            exp_data = 32'h0;
        end else if (i_stb) begin
            model_byte(i_byte);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("o_stb", {31'b0, o_stb}, {31'b0, exp_stb});
            check("o_err", {31'b0, o_err}, {31'b0, exp_err});
            check("o_data", o_data, exp_data);
            check("stb_err_exclusive", {31'b0, o_stb & o_err}, 32'h0);
            if (o_stb === 1'b1) n_stb++;
            if (o_err === 1'b1) n_err++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            i_stb = 1'b0;
        end
        @(negedge clk);
        i_stb  = 1'b1;
        i_byte = b;
    endtask

    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], $urandom_range(0, max_gap));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_stb = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        i_stb   = 1'b1;
        i_byte  = 8'h30;
        @(negedge clk);
        i_reset = 1'b0;
        i_stb   = 1'b0;
    endtask

    task automatic expect_counts(input string name, input int s0, input int e0,
                                 input int ds, input int de, input logic [31:0] data);
        idle(3);
        check({name, "_stb_count"}, n_stb - s0, ds);
        check({name, "_err_count"}, n_err - e0, de);
        check({name, "_data"}, o_data, data);
        check({name, "_model_data"}, exp_data, data);
    endtask

    initial begin
        int s0, e0;
        string hexchars;
        cr_s = $sformatf("%c", 8'h0D);
        lf_s = $sformatf("%c", 8'h0A);
        hexchars = "0123456789abcdefABCDEF";
        i_reset = 1'b1;
        i_stb   = 1'b0;
        i_byte  = 8'h00;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        check("reset_stb", {31'b0, o_stb}, 32'h0);
        check("reset_err", {31'b0, o_err}, 32'h0);
        check("reset_data", o_data, 32'h0);
        armed = 1'b1;

        s0 = n_stb; e0 = n_err;
        send_str({"0xdeadbeef", cr_s}, 0);
        send_byte(8'h0A, 0);
        check("stb_latency", {31'b0, o_stb}, 32'h1);
        expect_counts("deadbeef", s0, e0, 1, 0, 32'hDEADBEEF);

        s0 = n_stb; e0 = n_err;
        send_str({"0X1F", lf_s}, 3);
        expect_counts("1f_gaps", s0, e0, 1, 0, 32'h0000001F);

        s0 = n_stb; e0 = n_err;
        send_str({"0x123456789", cr_s, lf_s}, 0);
        expect_counts("overflow", s0, e0, 0, 1, 32'h0000001F);
        s0 = n_stb; e0 = n_err;
        send_str({"0x5", cr_s, lf_s}, 0);
        expect_counts("after_overflow", s0, e0, 1, 0, 32'h00000005);

        s0 = n_stb; e0 = n_err;
        send_str({"0xg", cr_s, lf_s, "0xA", lf_s}, 1);
        expect_counts("bad_digit", s0, e0, 1, 1, 32'h0000000A);

        s0 = n_stb; e0 = n_err;
        send_str({"0x", cr_s, "0x7", cr_s}, 0);
        expect_counts("empty_digits", s0, e0, 1, 1, 32'h00000007);

        s0 = n_stb; e0 = n_err;
        send_str("0xabc", 0);
        do_reset();
        send_str({"def", cr_s}, 0);
        expect_counts("reset_midline", s0, e0, 0, 1, 32'h00000000);
        send_str(lf_s, 0);

        for (int ln = 0; ln < 300; ln++) begin
            string s;
            int kind, nd;
            s = "";
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) s = " ";
            if ($urandom_range(0, 1) == 1) s = {s, "0x"};
            else s = {s, "0X"};
            if (kind <= 5) nd = $urandom_range(1, 8);
            else if (kind == 6) nd = $urandom_range(9, 10);
            else if (kind == 7) nd = $urandom_range(0, 4);
            else if (kind == 8) nd = 0;
            else nd = $urandom_range(1, 5);
            for (int d = 0; d < nd; d++)
                s = {s, $sformatf("%c", hexchars[$urandom_range(0, 21)])};
            if (kind == 7) s = {s, $sformatf("%c", 8'($urandom_range(0, 255)))};
            if (kind != 9) begin
                case ($urandom_range(0, 2))
                    0: s = {s, cr_s};
                    1: s = {s, lf_s};
                    default: s = {s, cr_s, lf_s};
                endcase
                if (kind >= 6) s = {s, lf_s};
            end
            send_str(s, 2);
            if (kind == 9) do_reset();
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
